// File: rtl/ctrl_unit_if.sv
// ----------------------------------------------------------------------------
// ctrl_unit_if
// Groups the pipeline controller's stimulus and control-output signals.
//
//   I_enable       pipeline enable (0 = freeze request)
//   I_mem_ready    memory handshake complete this cycle
//   I_mem_mode     00 NOP, 01 READ, 10 WRITE, 11 NOP
//   I_irq_req      pending interrupt request
//   I_irq_enable   interrupt-enable flag from the ALU
//   O_state        current state code
//   O_*_en         per-stage enables
//   O_mem_req      memory request
//   O_irq_active   IRQ state indicator
//   O_irq_ack      IRQ acknowledge pulse
//   O_timeout      high while halted on a handshake timeout
//
// Modports: slave = controller view, master = environment view.
// ----------------------------------------------------------------------------
interface ctrl_unit_if;
  logic       I_enable;
  logic       I_mem_ready;
  logic [1:0] I_mem_mode;
  logic       I_irq_req;
  logic       I_irq_enable;

  logic [2:0] O_state;
  logic       O_fetch_en;
  logic       O_decode_en;
  logic       O_regread_en;
  logic       O_alu_en;
  logic       O_mem_en;
  logic       O_writeback_en;
  logic       O_mem_req;
  logic       O_irq_active;
  logic       O_irq_ack;
  logic       O_timeout;

  modport slave (
    input  I_enable, I_mem_ready, I_mem_mode, I_irq_req, I_irq_enable,
    output O_state, O_fetch_en, O_decode_en, O_regread_en, O_alu_en,
           O_mem_en, O_writeback_en, O_mem_req, O_irq_active, O_irq_ack,
           O_timeout
  );

  modport master (
    output I_enable, I_mem_ready, I_mem_mode, I_irq_req, I_irq_enable,
    input  O_state, O_fetch_en, O_decode_en, O_regread_en, O_alu_en,
           O_mem_en, O_writeback_en, O_mem_req, O_irq_active, O_irq_ack,
           O_timeout
  );
endinterface

// File: rtl/ctrl_unit.sv
// ----------------------------------------------------------------------------
// ctrl_unit
// Six-stage pipeline sequencer (FETCH, DECODE, REGREAD, ALU, MEM, WB) with a
// one-cycle interrupt state and a HALT state entered when a memory handshake
// waits longer than MEM_WAIT_MAX cycles.
//
// Parameters:
//   MEM_WAIT_MAX  maximum handshake wait cycles; 0 disables the timeout.
//                 Only the low 8 bits are meaningful (8-bit wait counter).
// Ports:
//   I_clk         clock, rising edge
//   I_reset       synchronous active-low reset
//   bus           ctrl_unit_if.slave, handshake inputs and control outputs
//
// Outputs are a decode of the registered state; I_mem_mode gates the MEM
// request and I_enable gates the freezable stages.
// ----------------------------------------------------------------------------
module ctrl_unit #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic          I_clk,
  input  logic          I_reset,
  ctrl_unit_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_REGREAD = 3'd2,
    ST_ALU     = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_IRQ     = 3'd6,
    ST_HALT    = 3'd7
  } state_t;

  localparam logic [7:0] LP_LIMIT  = 8'(MEM_WAIT_MAX);
  localparam bit         LP_TO_EN  = (MEM_WAIT_MAX != 0);

  state_t     r_state;
  logic [7:0] r_wait_cnt;

  logic w_mem_access;
  logic w_limit_hit;
  logic w_freeze;
  logic w_irq_take;

  // READ and WRITE are the only modes that perform a handshake.
  function automatic logic is_mem_access(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  // Saturating so a disabled timeout can never wrap back onto a stale limit.
  function automatic logic [7:0] cnt_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Only the pure pipeline stages freeze; FETCH and MEM must finish their
  // handshakes regardless of I_enable, and HALT has nothing to freeze.
  function automatic logic is_freezable(input state_t st);
    return (st == ST_DECODE) || (st == ST_REGREAD) || (st == ST_ALU) ||
           (st == ST_WB)     || (st == ST_IRQ);
  endfunction

  assign w_mem_access = is_mem_access(bus.I_mem_mode);
  assign w_limit_hit  = LP_TO_EN && (r_wait_cnt == LP_LIMIT);
  assign w_freeze     = !bus.I_enable && is_freezable(r_state);
  assign w_irq_take   = bus.I_irq_req && bus.I_irq_enable;

  // --------------------------------------------------------------------------
  // State register and wait counter
  // I_mem_ready is tested before the limit so a handshake completing on the
  // limit cycle proceeds normally instead of halting.
  // --------------------------------------------------------------------------
  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.I_mem_ready) begin
            r_state    <= ST_DECODE;
            r_wait_cnt <= 8'd0;
          end else if (w_limit_hit) begin
            r_state    <= ST_HALT;
          end else begin
            r_wait_cnt <= cnt_inc(r_wait_cnt);
          end
        end

        ST_DECODE: begin
          if (bus.I_enable) r_state <= ST_REGREAD;
        end

        ST_REGREAD: begin
          if (bus.I_enable) r_state <= ST_ALU;
        end

        ST_ALU: begin
          if (bus.I_enable) begin
            r_state    <= ST_MEM;
            r_wait_cnt <= 8'd0;
          end
        end

        ST_MEM: begin
          if (!w_mem_access || bus.I_mem_ready) begin
            r_state    <= ST_WB;
            r_wait_cnt <= 8'd0;
          end else if (w_limit_hit) begin
            r_state    <= ST_HALT;
          end else begin
            r_wait_cnt <= cnt_inc(r_wait_cnt);
          end
        end

        ST_WB: begin
          // The interrupt request is only looked at here; earlier pulses
          // are dropped.
          if (bus.I_enable) begin
            if (w_irq_take) begin
              r_state <= ST_IRQ;
            end else begin
              r_state    <= ST_FETCH;
              r_wait_cnt <= 8'd0;
            end
          end
        end

        ST_IRQ: begin
          if (bus.I_enable) begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= 8'd0;
          end
        end

        default: begin
          // HALT: only reset leaves this state.
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  logic w_fetch_en;
  logic w_decode_en;
  logic w_regread_en;
  logic w_alu_en;
  logic w_mem_en;
  logic w_writeback_en;
  logic w_mem_req;
  logic w_irq_active;

  always_comb begin
    w_fetch_en     = 1'b0;
    w_decode_en    = 1'b0;
    w_regread_en   = 1'b0;
    w_alu_en       = 1'b0;
    w_mem_en       = 1'b0;
    w_writeback_en = 1'b0;
    w_mem_req      = 1'b0;
    w_irq_active   = 1'b0;
    if (!w_freeze) begin
      case (r_state)
        ST_FETCH: begin
          w_fetch_en = 1'b1;
          w_mem_req  = 1'b1;
        end
        ST_DECODE:  w_decode_en    = 1'b1;
        ST_REGREAD: w_regread_en   = 1'b1;
        ST_ALU:     w_alu_en       = 1'b1;
        ST_MEM: begin
          w_mem_en  = w_mem_access;
          w_mem_req = w_mem_access;
        end
        ST_WB:      w_writeback_en = 1'b1;
        ST_IRQ:     w_irq_active   = 1'b1;
        default: begin
          w_fetch_en = 1'b0;
        end
      endcase
    end
  end

  assign bus.O_state        = r_state;
  assign bus.O_fetch_en     = w_fetch_en;
  assign bus.O_decode_en    = w_decode_en;
  assign bus.O_regread_en   = w_regread_en;
  assign bus.O_alu_en       = w_alu_en;
  assign bus.O_mem_en       = w_mem_en;
  assign bus.O_writeback_en = w_writeback_en;
  assign bus.O_mem_req      = w_mem_req;
  assign bus.O_irq_active   = w_irq_active;
  assign bus.O_irq_ack      = w_irq_active;
  assign bus.O_timeout      = (r_state == ST_HALT);

endmodule

// File: tb/tb_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_ctrl_unit
// Directed bench for ctrl_unit with MEM_WAIT_MAX = 4.
// Output vector bit order (MSB first):
//   fetch, decode, regread, alu, mem_en, wb, mem_req, irq_active, irq_ack,
//   timeout
// ----------------------------------------------------------------------------
module tb_ctrl_unit;

  localparam logic [9:0] E_FETCH = 10'b1000001000;
  localparam logic [9:0] E_DEC   = 10'b0100000000;
  localparam logic [9:0] E_RR    = 10'b0010000000;
  localparam logic [9:0] E_ALU   = 10'b0001000000;
  localparam logic [9:0] E_MEMN  = 10'b0000000000;
  localparam logic [9:0] E_MEMA  = 10'b0000101000;
  localparam logic [9:0] E_WB    = 10'b0000010000;
  localparam logic [9:0] E_IRQ   = 10'b0000000110;
  localparam logic [9:0] E_HALT  = 10'b0000000001;
  localparam logic [9:0] E_NONE  = 10'b0000000000;

  logic I_clk;
  logic I_reset;
  int   n_vec;
  int   n_fail;

  ctrl_unit_if bus ();

  ctrl_unit #(.MEM_WAIT_MAX(4)) dut (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .bus     (bus)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  logic [9:0] outs;
  assign outs = {bus.O_fetch_en, bus.O_decode_en, bus.O_regread_en,
                 bus.O_alu_en, bus.O_mem_en, bus.O_writeback_en,
                 bus.O_mem_req, bus.O_irq_active, bus.O_irq_ack,
                 bus.O_timeout};

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp_st,
                     input logic [9:0] exp_o);
    #1;
    n_vec++;
    assert (bus.O_state === exp_st) else begin
      n_fail++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, bus.O_state, exp_st);
    end
    n_vec++;
    assert (outs === exp_o) else begin
      n_fail++;
      $error("FAIL %s outs observed=%b expected=%b", tag, outs, exp_o);
    end
  endtask

  // From FETCH with I_mem_ready=1 and NOP mode: five edges reach WB.
  task automatic go_wb();
    for (int i = 0; i < 5; i++) tick();
  endtask

  logic [2:0] seq_st [6];
  logic [9:0] seq_o  [6];

  initial begin
    n_vec  = 0;
    n_fail = 0;
    seq_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    seq_o  = '{E_FETCH, E_DEC, E_RR, E_ALU, E_MEMN, E_WB};

    I_reset          = 1'b0;
    bus.I_enable     = 1'b1;
    bus.I_mem_ready  = 1'b1;
    bus.I_mem_mode   = 2'b00;
    bus.I_irq_req    = 1'b0;
    bus.I_irq_enable = 1'b0;

    // Reset held two cycles, then released.
    tick();
    chk("rst_c1", 3'd0, E_FETCH);
    tick();
    chk("rst_c2", 3'd0, E_FETCH);
    I_reset = 1'b1;
    chk("rst_rel", 3'd0, E_FETCH);

    // Zero-wait, NOP memory: 0..5 repeating twice.
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("nop_seq%0d", i), seq_st[i % 6], seq_o[i % 6]);
      tick();
    end
    chk("nop_wrap", 3'd0, E_FETCH);

    // READ with three wait cycles in MEM.
    tick(); tick(); tick();
    chk("rd_alu", 3'd3, E_ALU);
    bus.I_mem_mode  = 2'b01;
    bus.I_mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rd_wait%0d", i), 3'd4, E_MEMA);
      tick();
    end
    bus.I_mem_ready = 1'b1;
    chk("rd_done", 3'd4, E_MEMA);
    tick();
    chk("rd_wb", 3'd5, E_WB);
    bus.I_mem_mode = 2'b00;
    tick();
    chk("rd_fetch", 3'd0, E_FETCH);

    // Interrupt taken in WB.
    go_wb();
    bus.I_irq_req    = 1'b1;
    bus.I_irq_enable = 1'b1;
    chk("irq_wb", 3'd5, E_WB);
    tick();
    chk("irq_pulse", 3'd6, E_IRQ);
    bus.I_irq_req = 1'b0;
    tick();
    chk("irq_fetch", 3'd0, E_FETCH);

    // Interrupt masked: WB goes straight to FETCH.
    bus.I_irq_req    = 1'b1;
    bus.I_irq_enable = 1'b0;
    go_wb();
    chk("irqm_wb", 3'd5, E_WB);
    tick();
    chk("irqm_fetch", 3'd0, E_FETCH);

    // Request dropped before WB is lost.
    bus.I_irq_enable = 1'b1;
    tick();
    bus.I_irq_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("irql_wb", 3'd5, E_WB);
    tick();
    chk("irql_fetch", 3'd0, E_FETCH);
    bus.I_irq_enable = 1'b0;

    // Freeze for three cycles in DECODE.
    tick();
    bus.I_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frz_dec%0d", i), 3'd1, E_NONE);
      tick();
    end
    bus.I_enable = 1'b1;
    chk("frz_resume", 3'd1, E_DEC);
    tick();
    chk("frz_rr", 3'd2, E_RR);
    tick(); tick(); tick(); tick();
    chk("frz_fetch", 3'd0, E_FETCH);

    // Freeze request during a FETCH wait has no effect on the handshake.
    bus.I_mem_ready = 1'b0;
    bus.I_enable    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("frzf_wait%0d", i), 3'd0, E_FETCH);
      tick();
    end
    bus.I_mem_ready = 1'b1;
    chk("frzf_rdy", 3'd0, E_FETCH);
    tick();
    chk("frzf_dec", 3'd1, E_NONE);
    bus.I_enable = 1'b1;
    chk("frzf_dec_en", 3'd1, E_DEC);
    tick(); tick(); tick(); tick(); tick();
    chk("frzf_fetch", 3'd0, E_FETCH);

    // Ready arrives on the limit cycle: no HALT.
    bus.I_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lim_wait%0d", i), 3'd0, E_FETCH);
      tick();
    end
    bus.I_mem_ready = 1'b1;
    chk("lim_cycle", 3'd0, E_FETCH);
    tick();
    chk("lim_dec", 3'd1, E_DEC);
    tick(); tick(); tick(); tick(); tick();
    chk("lim_fetch", 3'd0, E_FETCH);

    // Ready never comes: HALT after five FETCH cycles.
    bus.I_mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to_wait%0d", i), 3'd0, E_FETCH);
      tick();
    end
    chk("to_halt", 3'd7, E_HALT);
    bus.I_mem_ready = 1'b1;
    bus.I_enable    = 1'b0;
    tick();
    chk("to_hold1", 3'd7, E_HALT);
    bus.I_enable = 1'b1;
    tick();
    chk("to_hold2", 3'd7, E_HALT);
    I_reset = 1'b0;
    tick();
    chk("to_rst", 3'd0, E_FETCH);
    I_reset = 1'b1;
    chk("to_rel", 3'd0, E_FETCH);

    // Reset in MEM with a pending READ.
    tick(); tick(); tick();
    bus.I_mem_mode  = 2'b01;
    bus.I_mem_ready = 1'b0;
    tick();
    chk("mrst_mem0", 3'd4, E_MEMA);
    tick();
    chk("mrst_mem1", 3'd4, E_MEMA);
    I_reset = 1'b0;
    tick();
    chk("mrst_fetch", 3'd0, E_FETCH);
    n_vec++;
    assert (dut.r_wait_cnt === 8'd0) else begin
      n_fail++;
      $error("FAIL mrst_cnt observed=%0d expected=0", dut.r_wait_cnt);
    end
    I_reset = 1'b1;
    bus.I_mem_mode = 2'b00;
    chk("mrst_rel", 3'd0, E_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
